// File: rtl/step_delay_timer.sv
// step_delay_timer: prescaled step-period countdown answering the stepper FSM delay handshake
// Ports: clk, reset_n (async active-low); start_delay_counter arms/reloads from delay_value;
//        enable_delay_counter gates counting; delay_done holds high after expiry until the next start;
//        busy is high while ARMED or COUNT; remaining reports the time units still to elapse.
// Optional: define STEP_DELAY_TIMER_SCALE_EN to add delay_scale[1:0], which stretches the time unit
//           to PRESCALE << delay_scale cycles, latched on the start cycle.
module step_delay_timer #(
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16,
    parameter int VALUE_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_delay_counter,
    input  logic               enable_delay_counter,
    input  logic [VALUE_W-1:0] delay_value,
`ifdef STEP_DELAY_TIMER_SCALE_EN
    input  logic [1:0]         delay_scale,
`endif
    output logic               delay_done,
    output logic               busy,
    output logic [VALUE_W-1:0] remaining
);
`ifdef STEP_DELAY_TIMER_SCALE_EN
    localparam int PW = PRESCALE_W + 3;
`else
    localparam int PW = PRESCALE_W;
`endif
    typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;
    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d, last;
    logic [VALUE_W-1:0] rem_q, rem_d;
    logic               done_q, done_d, busy_q, busy_d;
`ifdef STEP_DELAY_TIMER_SCALE_EN
    logic [1:0]         scale_q, scale_d;
    assign last = (PW'(PRESCALE) << scale_q) - PW'(1);
`else
    assign last = PW'(PRESCALE - 1);
`endif
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        done_d  = done_q;
`ifdef STEP_DELAY_TIMER_SCALE_EN
        scale_d = scale_q;
`endif
        if (start_delay_counter) begin
            state_d = ARMED;
            pre_d   = '0;
            rem_d   = delay_value;
            done_d  = 1'b0;
`ifdef STEP_DELAY_TIMER_SCALE_EN
            scale_d = delay_scale;
`endif
        end else if (enable_delay_counter && (state_q == ARMED || state_q == COUNT)) begin
            if (state_q == ARMED && rem_q == '0) begin
                // zero-length delay completes after a single enabled cycle
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                state_d = COUNT;
                if (pre_q == last) begin
                    pre_d = '0;
                    rem_d = rem_q - VALUE_W'(1);
                    if (rem_q == VALUE_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end
        busy_d = (state_d == ARMED) || (state_d == COUNT);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef STEP_DELAY_TIMER_SCALE_EN
            scale_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef STEP_DELAY_TIMER_SCALE_EN
            scale_q <= scale_d;
`endif
        end
    end
    assign delay_done = done_q;
    assign busy       = busy_q;
    assign remaining  = rem_q;
endmodule

// File: doc/step_delay_timer.md
Name: step_delay_timer

Overview:
- Responder side of the step-delay handshake used by the stepper controller FSM.
- The FSM pulses start_delay_counter to arm a delay. It holds enable_delay_counter while waiting. It watches delay_done to leave its delay state.
- This block loads the step period from the datapath, divides the clock into time units with a prescaler, and counts the period down. It raises delay_done and holds it until the next start.
- It sits beside the control FSM in the ASIP top level. The only other connection is to the register-file read port that supplies the delay value.

Parameters:
- PRESCALE, 50000, clock cycles per time unit (1 ms at 50 MHz); must be >= 2.
- PRESCALE_W, 16, width of the prescaler counter; must satisfy 2**PRESCALE_W >= PRESCALE.
- VALUE_W, 8, width of the delay value and the remaining-count output.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_delay_counter  in  1  single-cycle arm/restart request from the control FSM.
- enable_delay_counter  in  1  level; counting advances only while this is high.
- delay_value  in  VALUE_W  delay length in time units, sampled on the cycle start_delay_counter is high.
- delay_done  out  1  registered level; high once the delay has expired, until the next start or reset.
- busy  out  1  high in ARMED or COUNT.
- remaining  out  VALUE_W  time units still to elapse (debug/status).

Behaviour:
- Reset: reset_n low forces the following immediately, regardless of clk:
  - state=IDLE, delay_done=0, busy=0, remaining=0, prescaler=0.
  - Any delay in progress is abandoned.
- States: IDLE, ARMED, COUNT, DONE (2-bit encoding).
- start_delay_counter=1 in any state, at edge t:
  - remaining<=delay_value, prescaler<=0, delay_done<=0, state<=ARMED.
  - start has priority over enable in the same cycle; no count occurs on the load cycle.
- ARMED, enable=1:
  - If remaining==0, then delay_done<=1 and state<=DONE (zero-length delay = 1 enabled cycle).
  - Otherwise the prescaler steps exactly as in COUNT on this cycle, and state<=COUNT.
- ARMED/COUNT, enable=1, prescaler counting:
  - If prescaler==PRESCALE-1, then prescaler<=0 and remaining<=remaining-1.
  - Otherwise prescaler<=prescaler+1.
- COUNT, expiry: when the decrement takes remaining from 1 to 0, the same edge sets delay_done<=1 and state<=DONE.
- Latency: with enable held high from the first cycle in ARMED, delay_done rises on the edge ending the (delay_value*PRESCALE)-th enabled cycle.
- Pause: enable=0 in ARMED or COUNT holds prescaler, remaining and state unchanged, so total latency grows by exactly the number of disabled cycles.
- IDLE or DONE: enable is ignored; delay_done holds its value; no counter moves.
- Restart mid-count: a start in COUNT reloads from the new delay_value and restarts the prescaler. delay_done stays 0 throughout.
- Restart in DONE: delay_done clears on the load edge.
- Wrap: remaining never decrements below 0; the prescaler never exceeds PRESCALE-1.
- busy = (state==ARMED || state==COUNT), registered together with the state.

Optional Feature:
- Macro: STEP_DELAY_TIMER_SCALE_EN.
- Defined:
  - Adds input delay_scale [1:0], latched on the start cycle.
  - The effective time unit becomes PRESCALE << delay_scale cycles (x1, x2, x4, x8).
  - The prescaler is widened by 3 bits internally.
  - Zero-length and pause rules are unchanged.
- Not defined: no delay_scale port; the time unit is always PRESCALE cycles.

Test Plan:
- PRESCALE=4, delay_value=3, one-cycle start, then enable held -> remaining steps 3,2,1,0 every 4 cycles; delay_done rises after exactly 12 enabled cycles; busy falls on the same edge.
- delay_value=0, start, then enable -> delay_done=1 after 1 enabled cycle; remaining stays 0.
- PRESCALE=4, delay_value=2, enable dropped for 5 cycles after 3 enabled cycles -> delay_done after 13 total cycles from ARMED entry; counters frozen during the gap.
- delay_value=5 running; at remaining=3 pulse start with delay_value=2 -> reload to 2; delay_done after 8 further enabled cycles; never high in between.
- reset_n asserted mid-COUNT between clock edges -> delay_done, busy and remaining read 0 before the next edge; no done after reset release without a new start.
- With STEP_DELAY_TIMER_SCALE_EN, PRESCALE=4, delay_scale=2'b10, delay_value=1 -> delay_done after 16 enabled cycles.
